// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: control bus from the decoder into the execute/storage datapath
// and the result/stall signals returned to PC/control logic.
interface cpu_datapath_if;
    logic       REG_WRITE_EN;
    logic [2:0] WRITE_ADDR;
    logic [2:0] READ_ADDR1;
    logic [2:0] READ_ADDR2;
    logic [7:0] IMM;
    logic       SEL_IMM;
    logic       SEL_NEG;
    logic [2:0] ALUOP;
    logic       SHIFT_DIR;
    logic       SEL_DMEM_ALU;
    logic       MEM_READ;
    logic       MEM_WRITE;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALURESULT;
    logic       ZERO;
    logic [7:0] MEM_DATA;
    logic       BUSYWAIT;

    modport master (
        output REG_WRITE_EN, WRITE_ADDR, READ_ADDR1, READ_ADDR2, IMM, SEL_IMM, SEL_NEG,
               ALUOP, SHIFT_DIR, SEL_DMEM_ALU, MEM_READ, MEM_WRITE,
        input  REGOUT1, REGOUT2, ALURESULT, ZERO, MEM_DATA, BUSYWAIT
    );

    modport slave (
        input  REG_WRITE_EN, WRITE_ADDR, READ_ADDR1, READ_ADDR2, IMM, SEL_IMM, SEL_NEG,
               ALUOP, SHIFT_DIR, SEL_DMEM_ALU, MEM_READ, MEM_WRITE,
        output REGOUT1, REGOUT2, ALURESULT, ZERO, MEM_DATA, BUSYWAIT
    );
endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: 8x8 register file, 8-bit ALU and 256-byte busy-wait data memory.
// Define MUL_EN to build the ALUOP 4 multiplier; without it ALUOP 4 returns 8'h00.
module cpu_datapath #(
    parameter int MEM_LATENCY = 5
) (
    input logic           CLK,
    input logic           RESET,
    cpu_datapath_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 2);
    logic [7:0] regs [8];
    logic [7:0] mem [256];
    state_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic [7:0] in1, in2, alu, wr_data, addr_q, wdata_q, mem_data_q;
    logic [2:0] amt;
    logic       wr_q, req, start, done, busy;

    assign bus.REGOUT1 = regs[bus.READ_ADDR1];
    assign bus.REGOUT2 = regs[bus.READ_ADDR2];
    assign in1 = bus.REGOUT1;
    assign in2 = bus.SEL_IMM ? bus.IMM : bus.SEL_NEG ? 8'h00 - bus.REGOUT2 : bus.REGOUT2;
    assign amt = in2[2:0];

    always_comb begin
        alu = in2;
        case (bus.ALUOP)
            3'd1: alu = in1 + in2;
            3'd2: alu = in1 & in2;
            3'd3: alu = in1 | in2;
`ifdef MUL_EN
            3'd4: alu = in1 * in2;
`else
            3'd4: alu = 8'h00;
`endif
            3'd5: alu = bus.SHIFT_DIR ? in1 >> amt : in1 << amt;
            3'd6: alu = 8'($signed(in1) >>> amt);
            3'd7: alu = (in1 >> amt) | (in1 << (4'd8 - {1'b0, amt}));
            default: alu = in2;
        endcase
    end

    assign bus.ALURESULT = alu;
    assign bus.ZERO      = alu == 8'h00;
    assign bus.BUSYWAIT  = busy;
    // Read data is visible in the completion cycle so a load can retire at that edge.
    assign bus.MEM_DATA  = done && !wr_q ? mem[addr_q] : mem_data_q;
    assign wr_data       = bus.SEL_DMEM_ALU ? alu : bus.MEM_DATA;
    assign req           = bus.MEM_READ || bus.MEM_WRITE;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        start     = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        if (state == IDLE) begin
            start = req;
            busy  = req;
            state_nxt = req ? BUSY : IDLE;
            count_nxt = req ? CNT_INIT : count;
        end else if (count != 4'd0) begin
            busy      = 1'b1;
            count_nxt = count - 4'd1;
        end else begin
            done      = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            count   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (start) begin
                addr_q  <= alu;
                wdata_q <= in1;
                wr_q    <= bus.MEM_WRITE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs       <= '{default: 8'h00};
            mem        <= '{default: 8'h00};
            mem_data_q <= 8'h00;
        end else begin
            if (bus.REG_WRITE_EN && !busy) regs[bus.WRITE_ADDR] <= wr_data;
            if (done && wr_q) mem[addr_q] <= wdata_q;
            if (done && !wr_q) mem_data_q <= mem[addr_q];
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: table-driven ALU vectors, directed memory sequences and
// randomized instructions checked against a behavioural model of the datapath.
module tb_cpu_datapath;
    localparam int LAT = 5;
`ifdef MUL_EN
    localparam logic [7:0] MULX = 8'h84;
`else
    localparam logic [7:0] MULX = 8'h00;
`endif

    typedef struct packed {
        logic [7:0] imm;
        logic       si, sn;
        logic [2:0] op;
        logic       dir;
        logic [2:0] ra1, ra2, wa;
        logic       we, dm, rd, wr;
    } ctl_t;

    typedef struct packed {
        logic [7:0] a, b, imm;
        logic       si, sn;
        logic [2:0] op;
        logic       dir;
        logic [7:0] res;
        logic       z;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] mregs [8];
    logic [7:0] mmem [256];
    logic [7:0] mdata;

    cpu_datapath_if bus();
    cpu_datapath #(.MEM_LATENCY(LAT)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic dir,
                                           input logic [7:0] a, input logic [7:0] b);
        int x, y, p, q, r;
        x = a;
        y = b;
        p = 2 ** (y % 8);
        case (op)
            3'd0: return b;
            3'd1: return 8'((x + y) % 256);
            3'd2: return a & b;
            3'd3: return a | b;
`ifdef MUL_EN
            3'd4: return 8'((x * y) % 256);
`else
            3'd4: return 8'h00;
`endif
            3'd5: return dir ? 8'(x / p) : 8'((x * p) % 256);
            3'd6: begin
                q = x >= 128 ? x - 256 : x;
                r = q / p;
                if (q < 0 && r * p != q) r--;
                return 8'(((r % 256) + 256) % 256);
            end
            default: return 8'(((x * 256 + x) / p) % 256);
        endcase
    endfunction

    function automatic ctl_t wimm(input logic [2:0] r, input logic [7:0] v);
        ctl_t c = '0;
        c.imm = v; c.si = 1'b1; c.wa = r; c.we = 1'b1; c.dm = 1'b1;
        return c;
    endfunction

    function automatic ctl_t memop(input logic w, input logic [7:0] addr,
                                   input logic [2:0] src, input logic [2:0] dst);
        ctl_t c = '0;
        c.imm = addr; c.si = 1'b1; c.ra1 = src; c.wa = dst;
        c.we = !w; c.rd = !w; c.wr = w;
        return c;
    endfunction

    task automatic drive(input ctl_t c);
        bus.IMM = c.imm; bus.SEL_IMM = c.si; bus.SEL_NEG = c.sn; bus.ALUOP = c.op;
        bus.SHIFT_DIR = c.dir; bus.READ_ADDR1 = c.ra1; bus.READ_ADDR2 = c.ra2;
        bus.WRITE_ADDR = c.wa; bus.REG_WRITE_EN = c.we; bus.SEL_DMEM_ALU = c.dm;
        bus.MEM_READ = c.rd; bus.MEM_WRITE = c.wr;
    endtask

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 8'h00;
        foreach (mmem[i]) mmem[i] = 8'h00;
        mdata = 8'h00;
    endtask

    // One instruction: ALU-only ops retire in one cycle, memory ops wait out BUSYWAIT.
    task automatic run(input ctl_t c, input bit scr);
        logic [7:0] a, b, res;
        int n;
        a = mregs[c.ra1];
        b = mregs[c.ra2];
        res = alu_ref(c.op, c.dir, a, c.si ? c.imm : c.sn ? 8'((256 - int'(b)) % 256) : b);
        drive(c);
        #1;
        check("regout1", bus.REGOUT1, a);
        check("regout2", bus.REGOUT2, b);
        check("aluresult", bus.ALURESULT, res);
        check("zero", bus.ZERO, res == 8'h00);
        if (!(c.rd || c.wr)) begin
            check("busy_idle", bus.BUSYWAIT, 8'h00);
            @(posedge CLK);
            #1;
            if (c.we) mregs[c.wa] = c.dm ? res : mdata;
        end else begin
            n = 0;
            while (bus.BUSYWAIT && n < 40) begin
                n++;
                @(posedge CLK);
                #1;
                if (scr) begin
                    bus.IMM = 8'($urandom);
                    bus.READ_ADDR1 = 3'($urandom);
                    bus.READ_ADDR2 = 3'($urandom);
                    bus.ALUOP = 3'($urandom);
                end
                #1;
            end
            check("busy_cycles", 8'(n), 8'(LAT - 1));
            if (c.wr) mmem[res] = a;
            else mdata = mmem[res];
            check("mem_data", bus.MEM_DATA, mdata);
            @(posedge CLK);
            #1;
            if (c.we) mregs[c.wa] = mdata;
        end
    endtask

    initial begin
        vec_t vecs [17];
        ctl_t c;
        logic [26:0] rnd;
        vecs[0]  = '{8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'h08, 1'b0};
        vecs[1]  = '{8'h05, 8'h03, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'h02, 1'b0};
        vecs[2]  = '{8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{8'hB4, 8'h00, 8'h02, 1'b1, 1'b0, 3'd5, 1'b0, 8'hD0, 1'b0};
        vecs[4]  = '{8'hB4, 8'h00, 8'h02, 1'b1, 1'b0, 3'd5, 1'b1, 8'h2D, 1'b0};
        vecs[5]  = '{8'hB4, 8'h00, 8'h02, 1'b1, 1'b0, 3'd6, 1'b0, 8'hED, 1'b0};
        vecs[6]  = '{8'hB4, 8'h00, 8'h04, 1'b1, 1'b0, 3'd7, 1'b0, 8'h4B, 1'b0};
        vecs[7]  = '{8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 8'h30, 1'b0};
        vecs[9]  = '{8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{8'hB4, 8'h00, 8'h08, 1'b1, 1'b0, 3'd7, 1'b0, 8'hB4, 1'b0};
        vecs[12] = '{8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'h07, 1'b0};
        vecs[14] = '{8'h0C, 8'h0B, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, MULX, MULX == 8'h00};
        vecs[15] = '{8'h81, 8'h00, 8'h07, 1'b1, 1'b0, 3'd6, 1'b0, 8'hFF, 1'b0};
        vecs[16] = '{8'h05, 8'h03, 8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 8'h06, 1'b0};

        c = '0;
        c.ra2 = 3'd7;
        drive(c);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        #1;
        check("rst_regout1", bus.REGOUT1, 8'h00);
        check("rst_regout2", bus.REGOUT2, 8'h00);
        check("rst_busywait", bus.BUSYWAIT, 8'h00);
        check("rst_mem_data", bus.MEM_DATA, 8'h00);
        @(posedge CLK);
        #1;

        run(wimm(3'd1, 8'h05), 1'b0);
        run(wimm(3'd2, 8'h03), 1'b0);
        c = '0; c.ra1 = 3'd1; c.ra2 = 3'd2;
        drive(c);
        #1;
        check("imm_r1", bus.REGOUT1, 8'h05);
        check("imm_r2", bus.REGOUT2, 8'h03);
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            run(wimm(3'd1, vecs[i].a), 1'b0);
            run(wimm(3'd2, vecs[i].b), 1'b0);
            c = '0; c.ra1 = 3'd1; c.ra2 = 3'd2; c.imm = vecs[i].imm; c.si = vecs[i].si;
            c.sn = vecs[i].sn; c.op = vecs[i].op; c.dir = vecs[i].dir;
            drive(c);
            #1;
            check($sformatf("vec%0d_alu", i), bus.ALURESULT, vecs[i].res);
            check($sformatf("vec%0d_zero", i), bus.ZERO, vecs[i].z);
            @(posedge CLK);
            #1;
        end

        // Back-to-back store/store/load/load with the request level never dropping.
        run(wimm(3'd1, 8'hAA), 1'b0);
        run(wimm(3'd2, 8'h5C), 1'b0);
        run(memop(1'b1, 8'h20, 3'd1, 3'd0), 1'b1);
        run(memop(1'b1, 8'h21, 3'd2, 3'd0), 1'b0);
        run(memop(1'b0, 8'h20, 3'd0, 3'd3), 1'b1);
        run(memop(1'b0, 8'h21, 3'd0, 3'd4), 1'b0);
        c = '0; c.ra1 = 3'd3; c.ra2 = 3'd4;
        drive(c);
        #1;
        check("load_r3", bus.REGOUT1, 8'hAA);
        check("load_r4", bus.REGOUT2, 8'h5C);
        @(posedge CLK);
        #1;
        c = memop(1'b1, 8'h40, 3'd2, 3'd0);
        c.rd = 1'b1;
        run(c, 1'b0);

        c = memop(1'b1, 8'h30, 3'd1, 3'd0);
        drive(c);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        bus.MEM_WRITE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        #1;
        check("midrst_busywait", bus.BUSYWAIT, 8'h00);
        check("midrst_mem_data", bus.MEM_DATA, 8'h00);
        check("midrst_r1", bus.REGOUT1, 8'h00);
        run(memop(1'b0, 8'h30, 3'd0, 3'd5), 1'b0);
        c = '0; c.ra1 = 3'd5;
        drive(c);
        #1;
        check("midrst_byte", bus.REGOUT1, 8'h00);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 300; i++) begin
            rnd = 27'($urandom);
            c = rnd;
            if ($urandom_range(0, 1) == 0) begin
                c.rd = 1'b0;
                c.wr = 1'b0;
            end
            if (c.rd || c.wr) c.dm = 1'b0;
            run(c, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Single-cycle execute/storage datapath of the 8-bit processor: 8×8 register file, 8-bit ALU with operand muxing, and a 256-byte data memory with busy-wait stall. The decoder drives the control inputs; this block returns ALU result, zero flag and a stall signal to the PC/control logic.

## Interface
Parameters:
- MEM_LATENCY, 5: data-memory access length in cycles, including the completion cycle; legal range 2..15.

Ports:
- One clock; reset is synchronous and active-high.
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous active-high reset.
- REG_WRITE_EN  in  1  register write request.
- WRITE_ADDR  in  3  destination register.
- READ_ADDR1 / READ_ADDR2  in  3 each  source registers for REGOUT1 / REGOUT2.
- IMM  in  8  immediate operand.
- SEL_IMM  in  1  1: ALU IN2 = IMM.
- SEL_NEG  in  1  1: ALU IN2 = two's complement of REGOUT2; ignored when SEL_IMM=1.
- ALUOP  in  3  ALU operation select.
- SHIFT_DIR  in  1  for ALUOP 5: 0 left, 1 right.
- SEL_DMEM_ALU  in  1  register write source: 1 ALU result, 0 memory read data.
- MEM_READ / MEM_WRITE  in  1 each  data-memory request levels.
- REGOUT1 / REGOUT2  out  8 each  combinational register reads.
- ALURESULT  out  8  ALU result, also the memory address.
- ZERO  out  1  ALURESULT == 0.
- MEM_DATA  out  8  last memory read data.
- BUSYWAIT  out  1  stall: memory access in progress.

## Operation
- ALU IN1 = REGOUT1. IN2 = IMM if SEL_IMM, else −REGOUT2 (mod 256) if SEL_NEG, else REGOUT2.
- ALUOP: 0 FWD (IN2); 1 ADD (mod 256); 2 AND; 3 OR; 4 MUL (low 8 bits of product); 5 logical shift of IN1 by IN2[2:0], direction per SHIFT_DIR, zero fill; 6 arithmetic right shift of IN1 by IN2[2:0]; 7 rotate right of IN1 by IN2[2:0]. Shift amount 0 returns IN1.
- Register file: 8 registers, all writable including r0. Read ports combinational; same-cycle write is not bypassed.
- Register write data = ALURESULT if SEL_DMEM_ALU else MEM_DATA.
- Register write at rising edge when REG_WRITE_EN=1 and BUSYWAIT=0.
- Memory: 256 bytes, address ALURESULT, write data REGOUT1. Controller states IDLE, BUSY (down-counter).
- IDLE with MEM_READ or MEM_WRITE high: BUSYWAIT=1 combinationally in the same cycle; next edge enters BUSY with count MEM_LATENCY−2.
- BUSY: BUSYWAIT=1 while count>0; count decrements each edge. Count==0 is the completion cycle: BUSYWAIT=0; read data (address latched at start) drives MEM_DATA combinationally; at that edge a write commits, MEM_DATA is registered, and state returns to IDLE.
- Request still high in the cycle after completion starts a new access, so back-to-back loads/stores each take MEM_LATENCY cycles.
- MEM_READ and MEM_WRITE both high: write performed, read ignored, MEM_DATA unchanged.
- Address and write data are latched when the access starts; later input changes do not affect it.
- Request dropped mid-access: access still completes.

## Timing
- Reset value at the edge with RESET=1: all registers 0, memory cleared to 0, controller IDLE, MEM_DATA=0, BUSYWAIT=0. Hence REGOUT1/2=0; ALURESULT and ZERO follow the current inputs.
- Reset mid-access aborts the access: no memory write, no register write.
- ALU/register-read path: zero-cycle combinational.
- Load: register updated at the end of cycle MEM_LATENCY after the request appears; store committed at the same edge.

## Configuration
- MUL_EN defined: ALUOP 4 multiplies.
- MUL_EN undefined: no multiplier; ALUOP 4 returns 8'h00 and ZERO=1.

## Test plan
- Reset, then write IMM 8'h05 to r1 (SEL_IMM, ALUOP 0), 8'h03 to r2 -> REGOUT1=5 / REGOUT2=3 on the next read.
- r1=5, r2=3: ADD -> 8'h08; SEL_NEG ADD -> 8'h02, ZERO=0; equal operands with SEL_NEG -> ZERO=1.
- r1=8'hB4: shift left by 2 -> 8'hD0; shift right by 2 -> 8'h2D; SRA by 2 -> 8'hED; ROR by 4 -> 8'h4B; MUL 8'h10×8'h10 -> 8'h00.
- Store r1=8'hAA at address 8'h20 (MEM_WRITE), then load to r3 -> BUSYWAIT high for exactly MEM_LATENCY−1 cycles each; r3=8'hAA.
- Two consecutive loads from addresses 8'h20 and 8'h21 with MEM_READ held high -> two separate MEM_LATENCY-cycle accesses, both registers correct.
- RESET asserted mid-store -> BUSYWAIT=0 next cycle, target byte still 0.
